seq_controller: RTL and testbench
=================================

Name: seq_controller

Overview:
- Sequential successor to the combinational 8-phase VeriRisc controller.
- Owns the phase counter and decodes phase/opcode into the nine datapath strobes.
- Adds three things over the combinational version:
  - a latched HALTED state with a go-restart;
  - memory wait-states via a mem_rdy handshake with a timeout;
  - a sticky FAULT state for illegal opcodes and memory timeouts.
- Sits between the instruction register/accumulator and the memory/PC/ALU datapath.

Parameters:
- OPC_W, 3, opcode width; codes 0..7 = HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP; codes >7 illegal (only reachable when OPC_W>3).
- WAIT_EN, 1, 1 = honour mem_rdy at stall phases; 0 = ignore mem_rdy, never stall.
- MAX_WAIT, 15, wait cycles allowed per stall before FAULT; 0 = unlimited.
- WAIT_W, 4, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPC_W  current instruction register opcode
- zero  in  1  accumulator is zero
- mem_rdy  in  1  memory access completes this cycle
- go  in  1  restart request, honoured only in HALTED
- sel  out  1  select instruction address to memory
- rd  out  1  memory output onto data bus
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment program counter
- halt  out  1  machine halted or faulted
- ld_pc  out  1  load program counter
- data_e  out  1  accumulator output onto data bus
- ld_ac  out  1  load accumulator
- wr  out  1  write data bus to memory
- phase  out  3  current phase
- busy  out  1  state==RUN
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:

Reset:
- rst has priority over every other input.
- Next cycle after reset: state=RUN, phase=0, wait counter=0, fault=0, fault_code=00.
- Outputs after reset: sel=1, busy=1; all other strobes 0, halt=0.

States: RUN, HALTED, FAULT.

Strobe decode in RUN (combinational from registered phase, opcode, zero):
- ph0: sel.
- ph1: sel, rd.
- ph2, ph3: sel, rd, ld_ir.
- ph4: inc_pc; also halt if opcode==HLT.
- ph5: rd if opcode is ADD, AND, XOR or LDA.
- ph6:
  - rd if ADD, AND, XOR or LDA;
  - data_e if STO;
  - ld_pc if JMP;
  - inc_pc if SKZ and zero==1 (zero is combinational, no latch).
- ph7:
  - rd and ld_ac if ADD, AND, XOR or LDA;
  - data_e and wr if STO;
  - ld_pc if JMP.
- All strobes not listed above are 0.

Phase advance:
- In RUN, phase increments each cycle and wraps 7->0, unless stalled.
- Stall phases:
  - ph3 (instruction fetch);
  - ph7 when opcode is ADD, AND, XOR, LDA or STO.
- With WAIT_EN=1 and mem_rdy=0 in a stall phase:
  - phase holds;
  - strobes stay at that phase's decode;
  - wait counter increments.
- On mem_rdy=1 in a stall phase, phase advances and the wait counter clears.
- The wait counter also clears on every non-stall cycle.

Timeout:
- Condition: MAX_WAIT!=0, in a stall phase, wait counter==MAX_WAIT and mem_rdy==0.
- Result next cycle: FAULT with fault_code=10.
- Consequence: exactly MAX_WAIT stall cycles are tolerated.

HLT:
- The ph4 cycle shows inc_pc=1, halt=1.
- Next cycle: state=HALTED, phase=0.

HALTED:
- halt=1, all other strobes 0, busy=0, phase held at 0.
- go=1 -> next cycle RUN at ph0.
- go is ignored in RUN and FAULT.

Illegal opcode:
- Condition: opcode>7 at ph4.
- That ph4 cycle shows inc_pc=1 only.
- Next cycle: FAULT with fault_code=01.

FAULT:
- halt=1, fault=1, all other strobes 0, busy=0, phase=0.
- Exits only on rst.

Other rules:
- Opcode changes mid-instruction take effect combinationally. The controller does not latch opcode; the IR is stable after ph3.
- With WAIT_EN=0 and OPC_W=3, the per-phase strobe table is bit-identical to the existing combinational controller for a free-running phase. The only differences are that after HLT the phase parks at 0 instead of continuing, and the halted strobe pattern is halt=1.

Test Plan:
1. Reset, WAIT_EN=0, mem_rdy=1; ADD instruction across 8 cycles -> {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}: 100000000, 110000000, 111000000, 111000000, 000100000, 010000000, 010000000, 010000010; phase wraps to 0.
2. SKZ: zero=0 at ph6 -> 000000000; zero=1 at ph6 -> 000100000.
3. STO with mem_rdy=0 for 3 cycles at ph7 -> 000000101 held 4 cycles in total, phase stays 7; mem_rdy=1 -> phase 0 next cycle, wait counter 0.
4. MAX_WAIT=2, mem_rdy held 0 at ph3:
   - ph3 held 3 cycles;
   - then FAULT, fault_code=10, halt=1, busy=0;
   - go=1 has no effect;
   - rst -> RUN at ph0.
5. HLT: ph4 -> 000110000; then HALTED, halt=1, phase=0 for 5 cycles; go pulse -> next cycle ph0, sel=1, busy=1.
6. OPC_W=4, opcode=9: ph4 inc_pc=1; next cycle fault=1, fault_code=01. Reset asserted mid-ph6 of a JMP -> next cycle ph0, fault=0.

Source files
------------

// File: rtl/seq_controller.sv
// Sequential VeriRisc controller: owns the 8-phase counter and decodes
// phase/opcode into datapath strobes, with halt/restart, memory wait-states and a sticky fault.
//
// state  | meaning
// RUN    | stepping through phases 0..7, strobes decoded from phase/opcode
// HALTED | HLT executed, phase parked at 0, waiting for go
// FAULT  | illegal opcode or memory timeout, left only through rst
module seq_controller #(
  parameter int OPC_W    = 3,
  parameter int WAIT_EN  = 1,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_rdy,
  input  logic             go,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code
);

  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        phase_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        code_d;
  logic [2:0]        op;
  logic              illegal;
  logic              is_hlt, is_skz, is_mem, is_sto, is_jmp;
  logic              stall_ph, timed_out;

  assign op = opcode[2:0];

  // Codes above 7 only exist when the opcode field is wider than 3 bits.
  generate
    if (OPC_W > 3) begin : g_wide
      assign illegal = |opcode[OPC_W-1:3];
    end else begin : g_narrow
      assign illegal = 1'b0;
    end
  endgenerate

  assign is_hlt = !illegal && (op == 3'd0);
  assign is_skz = !illegal && (op == 3'd1);
  assign is_mem = !illegal && (op inside {3'd2, 3'd3, 3'd4, 3'd5});
  assign is_sto = !illegal && (op == 3'd6);
  assign is_jmp = !illegal && (op == 3'd7);

  assign stall_ph  = (WAIT_EN != 0) &&
                     ((phase == 3'd3) || ((phase == 3'd7) && (is_mem || is_sto)));
  assign timed_out = (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    busy   = (state_q == RUN);
    fault  = (state_q == FAULT);
    case (state_q)
      RUN: begin
        case (phase)
          3'd0: sel = 1'b1;
          3'd1: begin
            sel = 1'b1;
            rd  = 1'b1;
          end
          3'd2, 3'd3: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
          end
          3'd4: begin
            inc_pc = 1'b1;
            halt   = is_hlt;
          end
          3'd5: rd = is_mem;
          3'd6: begin
            rd     = is_mem;
            data_e = is_sto;
            ld_pc  = is_jmp;
            inc_pc = is_skz && zero;
          end
          default: begin
            rd     = is_mem;
            ld_ac  = is_mem;
            data_e = is_sto;
            wr     = is_sto;
            ld_pc  = is_jmp;
          end
        endcase
      end
      default: halt = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    wait_d  = wait_q;
    code_d  = fault_code;
    case (state_q)
      RUN: begin
        if ((phase == 3'd4) && is_hlt) begin
          state_d = HALTED;
          phase_d = 3'd0;
          wait_d  = '0;
        end else if ((phase == 3'd4) && illegal) begin
          state_d = FAULT;
          phase_d = 3'd0;
          wait_d  = '0;
          code_d  = 2'b01;
        end else if (stall_ph && !mem_rdy) begin
          if (timed_out) begin
            state_d = FAULT;
            phase_d = 3'd0;
            wait_d  = '0;
            code_d  = 2'b10;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          phase_d = phase + 3'd1;
          wait_d  = '0;
        end
      end
      HALTED: begin
        if (go) begin
          state_d = RUN;
          phase_d = 3'd0;
        end
      end
      default: begin
        state_d = FAULT;
        phase_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      phase      <= 3'd0;
      wait_q     <= '0;
      fault_code <= 2'b00;
    end else begin
      state_q    <= state_d;
      phase      <= phase_d;
      wait_q     <= wait_d;
      fault_code <= code_d;
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Drives three differently parameterised controllers from shared inputs and
// checks every cycle against a phase/state reference model, plus directed plan steps.
module tb_seq_controller;

  localparam int P_OPW [3] = '{3, 3, 4};
  localparam int P_WEN [3] = '{0, 1, 1};
  localparam int P_MAX [3] = '{15, 15, 2};

  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd2;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b1;
  logic       go = 1'b0;

  logic       sel_o [3], rd_o [3], ld_ir_o [3], inc_pc_o [3], halt_o [3];
  logic       ld_pc_o [3], data_e_o [3], ld_ac_o [3], wr_o [3], busy_o [3], fault_o [3];
  logic [2:0] phase_o [3];
  logic [1:0] code_o [3];
  logic [15:0] obs [3];

  int m_st [3];
  int m_ph [3];
  int m_wt [3];
  int m_fc [3];
  bit model_valid = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_controller #(
      .OPC_W(P_OPW[g]), .WAIT_EN(P_WEN[g]), .MAX_WAIT(P_MAX[g]), .WAIT_W(4)
    ) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode[P_OPW[g]-1:0]), .zero(zero),
      .mem_rdy(mem_rdy), .go(go),
      .sel(sel_o[g]), .rd(rd_o[g]), .ld_ir(ld_ir_o[g]), .inc_pc(inc_pc_o[g]),
      .halt(halt_o[g]), .ld_pc(ld_pc_o[g]), .data_e(data_e_o[g]), .ld_ac(ld_ac_o[g]),
      .wr(wr_o[g]), .phase(phase_o[g]), .busy(busy_o[g]), .fault(fault_o[g]),
      .fault_code(code_o[g])
    );
    assign obs[g] = {sel_o[g], rd_o[g], ld_ir_o[g], inc_pc_o[g], halt_o[g], ld_pc_o[g],
                     data_e_o[g], ld_ac_o[g], wr_o[g], phase_o[g], busy_o[g], fault_o[g],
                     code_o[g]};
  end

  function automatic logic [15:0] pk(input logic [8:0] row, input int ph, input bit bsy,
                                     input bit flt, input int fc);
    return {row, 3'(ph), bsy, flt, 2'(fc)};
  endfunction

  function automatic int opc_of(input int i);
    return (P_OPW[i] == 4) ? int'(opcode) : int'(opcode[2:0]);
  endfunction

  // Strobe pattern {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} for one RUN phase.
  function automatic logic [8:0] row_of(input int ph, input int opc, input bit z);
    bit alu, sto, jmp;
    alu = (opc >= 2) && (opc <= 5);
    sto = (opc == 6);
    jmp = (opc == 7);
    case (ph)
      0: return 9'b100000000;
      1: return 9'b110000000;
      2, 3: return 9'b111000000;
      4: return (opc == 0) ? 9'b000110000 : 9'b000100000;
      5: return alu ? 9'b010000000 : 9'b000000000;
      6: return alu ? 9'b010000000 : sto ? 9'b000000100 : jmp ? 9'b000001000 :
                ((opc == 1) && z) ? 9'b000100000 : 9'b000000000;
      default: return alu ? 9'b010000010 : sto ? 9'b000000101 : jmp ? 9'b000001000 :
                9'b000000000;
    endcase
  endfunction

  function automatic logic [15:0] expect_of(input int i);
    if (m_st[i] == M_RUN) return pk(row_of(m_ph[i], opc_of(i), zero), m_ph[i], 1'b1, 1'b0, m_fc[i]);
    if (m_st[i] == M_HALT) return pk(9'b000010000, 0, 1'b0, 1'b0, m_fc[i]);
    return pk(9'b000010000, 0, 1'b0, 1'b1, m_fc[i]);
  endfunction

  task automatic model_next(input int i);
    int  opc;
    bit  stall;
    opc = opc_of(i);
    if (rst) begin
      m_st[i] = M_RUN; m_ph[i] = 0; m_wt[i] = 0; m_fc[i] = 0;
    end else if (m_st[i] == M_RUN) begin
      stall = (P_WEN[i] != 0) && ((m_ph[i] == 3) || ((m_ph[i] == 7) && (opc >= 2) && (opc <= 6)));
      if ((m_ph[i] == 4) && (opc == 0)) begin
        m_st[i] = M_HALT; m_ph[i] = 0; m_wt[i] = 0;
      end else if ((m_ph[i] == 4) && (opc > 7)) begin
        m_st[i] = M_FAULT; m_ph[i] = 0; m_wt[i] = 0; m_fc[i] = 1;
      end else if (stall && !mem_rdy) begin
        if ((P_MAX[i] != 0) && (m_wt[i] == P_MAX[i])) begin
          m_st[i] = M_FAULT; m_ph[i] = 0; m_wt[i] = 0; m_fc[i] = 2;
        end else begin
          m_wt[i] = (m_wt[i] + 1) % 16;
        end
      end else begin
        m_ph[i] = (m_ph[i] + 1) % 8;
        m_wt[i] = 0;
      end
    end else if ((m_st[i] == M_HALT) && go) begin
      m_st[i] = M_RUN; m_ph[i] = 0;
    end
  endtask

  // One clock: sample at the falling edge, check model (and optional directed value), advance.
  task automatic step(input int inst = -1, input logic [15:0] want = '0);
    logic [15:0] exp_v;
    @(negedge clk);
    if (model_valid) begin
      for (int i = 0; i < 3; i++) begin
        exp_v = expect_of(i);
        n_checks++;
        assert (obs[i] === exp_v) else begin
          n_fail++;
          $error("FAIL model_u%0d t=%0t observed %h expected %h", i, $time, obs[i], exp_v);
        end
      end
    end
    if (inst >= 0) begin
      n_checks++;
      assert (obs[inst] === want) else begin
        n_fail++;
        $error("FAIL plan_u%0d t=%0t observed %h expected %h", inst, $time, obs[inst], want);
      end
    end
    for (int i = 0; i < 3; i++) model_next(i);
    model_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] add_rows [8];
    add_rows = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010};

    // ADD on the classic (no wait-state) controller
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) step(0, pk(add_rows[c], c, 1'b1, 1'b0, 0));
    step(0, pk(9'b100000000, 0, 1'b1, 1'b0, 0));

    // SKZ with zero low then high at ph6 (phase now 1)
    opcode = 4'd1;
    for (int c = 1; c < 17; c++) begin
      zero = (c >= 9);
      if (c == 6) step(0, pk(9'b000000000, 6, 1'b1, 1'b0, 0));
      else if (c == 14) step(0, pk(9'b000100000, 6, 1'b1, 1'b0, 0));
      else step();
    end

    // STO with a 3-cycle memory stall at ph7 (phase now 1)
    opcode = 4'd6;
    for (int c = 1; c < 7; c++) step();
    mem_rdy = 1'b0;
    for (int c = 0; c < 3; c++) step(1, pk(9'b000000101, 7, 1'b1, 1'b0, 0));
    mem_rdy = 1'b1;
    step(1, pk(9'b000000101, 7, 1'b1, 1'b0, 0));
    step(1, pk(9'b100000000, 0, 1'b1, 1'b0, 0));

    // Fetch timeout with MAX_WAIT=2
    rst = 1'b1; step(); rst = 1'b0;
    opcode = 4'd2;
    for (int c = 0; c < 3; c++) step();
    mem_rdy = 1'b0;
    for (int c = 0; c < 3; c++) step(2, pk(9'b111000000, 3, 1'b1, 1'b0, 0));
    step(2, pk(9'b000010000, 0, 1'b0, 1'b1, 2));
    go = 1'b1;
    for (int c = 0; c < 2; c++) step(2, pk(9'b000010000, 0, 1'b0, 1'b1, 2));
    go = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    mem_rdy = 1'b1;
    step(2, pk(9'b100000000, 0, 1'b1, 1'b0, 0));

    // HLT then go restart
    rst = 1'b1; step(); rst = 1'b0;
    opcode = 4'd0;
    for (int c = 0; c < 4; c++) step();
    step(1, pk(9'b000110000, 4, 1'b1, 1'b0, 0));
    for (int c = 0; c < 5; c++) step(1, pk(9'b000010000, 0, 1'b0, 1'b0, 0));
    go = 1'b1;
    step(1, pk(9'b000010000, 0, 1'b0, 1'b0, 0));
    go = 1'b0;
    step(1, pk(9'b100000000, 0, 1'b1, 1'b0, 0));

    // Illegal opcode on the 4-bit controller, then reset in the middle of a JMP
    rst = 1'b1; step(); rst = 1'b0;
    opcode = 4'd9;
    for (int c = 0; c < 4; c++) step();
    step(2, pk(9'b000100000, 4, 1'b1, 1'b0, 0));
    step(2, pk(9'b000010000, 0, 1'b0, 1'b1, 1));
    rst = 1'b1; step(); rst = 1'b0;
    opcode = 4'd7;
    for (int c = 0; c < 6; c++) step();
    rst = 1'b1;
    step(2, pk(9'b000001000, 6, 1'b1, 1'b0, 0));
    rst = 1'b0;
    step(2, pk(9'b100000000, 0, 1'b1, 1'b0, 0));

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 63) == 0);
      opcode  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      zero    = 1'($urandom_range(0, 1));
      mem_rdy = ($urandom_range(0, 3) != 0);
      go      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
